// File: rtl/alu_ctrl_exec_pkg.sv
// Shared types and field positions for the accumulator-core execution block.
// FSM states, ALU opcodes and instruction-word layout.
package alu_ctrl_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_CAPT = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_MOVB = 3'd7
  } alu_op_t;

  localparam int RX_MSB  = 15;
  localparam int RX_LSB  = 13;
  localparam int RY_MSB  = 12;
  localparam int RY_LSB  = 10;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 5;
  localparam int SEL_MSB = 4;
  localparam int SEL_LSB = 2;
  localparam int FMT_MSB = 1;
  localparam int FMT_LSB = 0;

  localparam logic [1:0] FORMAT_IMM = 2'd1;

endpackage

// File: rtl/alu_ctrl_exec_alu_core.sv
// Registered 8-operation ALU; result updates on every run-enabled edge.
// Shifts use only the low four bits of operand B.
module alu_core
  import alu_ctrl_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out
);

  alu_op_t          op;
  logic [WIDTH-1:0] result;

  assign op = alu_op_t'(sel);

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = in_a + in_b;
      OP_SUB:  result = in_a - in_b;
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_SHL:  result = in_a << in_b[3:0];
      OP_SHR:  result = in_a >> in_b[3:0];
      OP_MOVB: result = in_b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out <= '0;
    end else if (run) begin
      alu_out <= result;
    end
  end

endmodule

// File: rtl/alu_ctrl_exec.sv
// Execution block: Moore sequencer (LOAD/EXEC/CAPT/WB) plus registered ALU.
// Enables are decoded from state and gated by run.
module alu_ctrl_exec
  import alu_ctrl_exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      instruction,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             en_s,
  output logic             en_c,
  output logic [NREGS-1:0] en_reg,
  output logic [WIDTH-1:0] alu_out,
  output logic             done
);

  state_t     state;
  state_t     state_nx;
  logic [2:0] rx_q;
  logic       unused_fields;

  // Register/immediate selection happens upstream; these bits are not used here.
  assign unused_fields = ^{instruction[IMM_MSB:IMM_LSB],
                           instruction[FMT_MSB:FMT_LSB]};

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_CAPT;
      ST_CAPT: state_nx = ST_WB;
      ST_WB:   state_nx = run ? ST_LOAD : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rx_q  <= '0;
    end else if (run) begin
      state <= state_nx;
      if (state == ST_LOAD) begin
        rx_q <= instruction[RX_MSB:RX_LSB];
      end
    end
  end

  assign en_s   = run && (state == ST_LOAD);
  assign en_c   = run && (state == ST_CAPT);
  assign done   = run && (state == ST_WB);
  assign en_reg = done ? (NREGS'(1) << rx_q) : '0;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .sel    (instruction[SEL_MSB:SEL_LSB]),
    .in_a   (in_a),
    .in_b   (in_b),
    .alu_out(alu_out)
  );

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec: vector table plus stall,
// back-to-back and mid-instruction reset sequences.
module tb_alu_ctrl_exec;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        en_s;
  logic        en_c;
  logic [7:0]  en_reg;
  logic [15:0] alu_out;
  logic        done;

  int nvec;
  int nmis;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic [2:0]  rx;
    logic [15:0] y;
    logic [7:0]  en;
  } vec_t;

  vec_t vt[10];

  alu_ctrl_exec #(
    .WIDTH(16),
    .NREGS(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instruction(instruction),
    .in_a       (in_a),
    .in_b       (in_b),
    .en_s       (en_s),
    .en_c       (en_c),
    .en_reg     (en_reg),
    .alu_out    (alu_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] rx, input logic [2:0] sel,
                        input logic [15:0] a, input logic [15:0] b);
    instruction = {rx, 8'h00, sel, 2'b00};
    in_a = a;
    in_b = b;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    reset = 1'b0;
    run = 1'b0;
    instruction = '0;
    in_a = '0;
    in_b = '0;

    vt[0] = '{16'h0003, 16'h0004, 3'd0, 3'd5, 16'h0007, 8'h20};
    vt[1] = '{16'h0000, 16'h0001, 3'd1, 3'd0, 16'hFFFF, 8'h01};
    vt[2] = '{16'hFFFF, 16'h0001, 3'd0, 3'd2, 16'h0000, 8'h04};
    vt[3] = '{16'h0001, 16'h0013, 3'd5, 3'd3, 16'h0008, 8'h08};
    vt[4] = '{16'hF0F0, 16'h0FF0, 3'd2, 3'd4, 16'h00F0, 8'h10};
    vt[5] = '{16'hF0F0, 16'h0FF0, 3'd3, 3'd6, 16'hFFF0, 8'h40};
    vt[6] = '{16'hF0F0, 16'h0FF0, 3'd4, 3'd7, 16'hFF00, 8'h80};
    vt[7] = '{16'hF0F0, 16'h0FF0, 3'd7, 3'd1, 16'h0FF0, 8'h02};
    vt[8] = '{16'hF0F0, 16'h0004, 3'd6, 3'd5, 16'h0F0F, 8'h20};
    vt[9] = '{16'h8421, 16'hFFF4, 3'd6, 3'd3, 16'h0842, 8'h08};

    step();
    chk("rst_en_s", en_s, 0);
    chk("rst_en_c", en_c, 0);
    chk("rst_en_reg", en_reg, 0);
    chk("rst_done", done, 0);
    chk("rst_alu", alu_out, 16'h0000);
    reset = 1'b1;
    #1;
    step();
    chk("idle_en_s", en_s, 0);
    chk("idle_done", done, 0);

    // Table vectors issued back to back with run held high.
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(vt[i].rx, vt[i].sel, vt[i].a, vt[i].b);
      step();
      chk($sformatf("v%0d_load_en_s", i), en_s, 1);
      chk($sformatf("v%0d_load_done", i), done, 0);
      chk($sformatf("v%0d_load_en_reg", i), en_reg, 0);
      step();
      chk($sformatf("v%0d_exec_en_s", i), en_s, 0);
      chk($sformatf("v%0d_exec_en_c", i), en_c, 0);
      step();
      chk($sformatf("v%0d_capt_en_c", i), en_c, 1);
      chk($sformatf("v%0d_capt_alu", i), alu_out, vt[i].y);
      step();
      chk($sformatf("v%0d_wb_en_reg", i), en_reg, vt[i].en);
      chk($sformatf("v%0d_wb_done", i), done, 1);
      chk($sformatf("v%0d_wb_en_c", i), en_c, 0);
    end

    // Stall for three cycles in EXEC.
    do_reset();
    set_op(3'd2, 3'd0, 16'h1234, 16'h0001);
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    in_a = 16'hAAAA;
    #1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_en_s", en_s, 0);
      chk("stall_en_c", en_c, 0);
      chk("stall_en_reg", en_reg, 0);
      chk("stall_done", done, 0);
      chk("stall_alu", alu_out, 16'h1235);
    end
    in_a = 16'h1234;
    run = 1'b1;
    step();
    chk("resume_capt_en_c", en_c, 1);
    chk("resume_capt_alu", alu_out, 16'h1235);
    step();
    chk("resume_wb_en_reg", en_reg, 8'h04);
    chk("resume_wb_done", done, 1);

    // Back-to-back, instruction changed during the first WB.
    do_reset();
    set_op(3'd1, 3'd0, 16'h0001, 16'h0001);
    run = 1'b1;
    step();
    step();
    step();
    chk("b2b0_alu", alu_out, 16'h0002);
    step();
    chk("b2b0_done", done, 1);
    chk("b2b0_en_reg", en_reg, 8'h02);
    set_op(3'd7, 3'd0, 16'h0002, 16'h0003);
    #1;
    chk("b2b0_en_reg_hold", en_reg, 8'h02);
    step();
    chk("b2b1_load_done", done, 0);
    chk("b2b1_load_en_s", en_s, 1);
    step();
    step();
    chk("b2b1_alu", alu_out, 16'h0005);
    chk("b2b1_capt_done", done, 0);
    step();
    chk("b2b1_done", done, 1);
    chk("b2b1_en_reg", en_reg, 8'h80);

    // Reset asserted mid-CAPT aborts without write-back.
    do_reset();
    set_op(3'd6, 3'd0, 16'h0005, 16'h0005);
    run = 1'b1;
    step();
    step();
    step();
    chk("rcapt_en_c", en_c, 1);
    reset = 1'b0;
    #1;
    chk("rasync_en_c", en_c, 0);
    chk("rasync_alu", alu_out, 16'h0000);
    step();
    chk("rhold_en_s", en_s, 0);
    chk("rhold_en_reg", en_reg, 0);
    chk("rhold_done", done, 0);
    chk("rhold_alu", alu_out, 16'h0000);
    reset = 1'b1;
    #1;
    step();
    chk("rel_en_s", en_s, 1);
    chk("rel_en_reg", en_reg, 0);
    chk("rel_done", done, 0);
    step();
    step();
    chk("rel_alu", alu_out, 16'h000A);
    step();
    chk("rel_en_reg_wb", en_reg, 8'h40);
    chk("rel_done_wb", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
